// File: rtl/pov_pkg.sv
// Shared POV link constants, transmitter state encoding and a counter-width helper.
// The receiver-side bit/character counters reload from these same constants.
package pov_pkg;
    localparam int CHAR_W_DEF  = 8;
    localparam int STR_LEN_DEF = 12;
    localparam int GAP_DEF     = 1;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_ARMED,
        ST_SEND,
        ST_GAP
    } tx_state_t;

    // Width of a counter spanning 0..range-1, never narrower than one bit.
    function automatic int cnt_w(input int range);
        return (range > 1) ? $clog2(range) : 1;
    endfunction
endpackage

// File: rtl/string_tx_if.sv
// Byte-load port, start/status handshake and serial framing outputs of string_tx.
// The master side drives characters and start; the slave side is the framer.
interface string_tx_if #(
    parameter int CHAR_W = 8
) ();
    logic [CHAR_W-1:0] char_in;
    logic              char_we;
    logic              char_ready;
    logic              start;
    logic              busy;
    logic              done;
    logic              TxData;
    logic              WriteChar;
    logic              WriteString;

    modport master (
        output char_in, char_we, start,
        input  char_ready, busy, done, TxData, WriteChar, WriteString
    );

    modport slave (
        input  char_in, char_we, start,
        output char_ready, busy, done, TxData, WriteChar, WriteString
    );
endinterface

// File: rtl/string_tx_char_shifter.sv
// Parallel-load shift register presenting its MSB; zeros fill from the LSB side,
// so the output idles low once a full character has been shifted out.
module char_shifter #(
    parameter int W = 8
) (
    input  logic         clk_2,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] dat,
    output logic         msb
);
    logic [W-1:0] sr;

    always_ff @(posedge clk_2) begin
        if (reset)
            sr <= '0;
        else if (load)
            sr <= dat;
        else if (shift)
            sr <= {sr[W-2:0], 1'b0};
    end

    assign msb = sr[W-1];
endmodule

// File: rtl/string_tx.sv
// POV string framer: buffers STR_LEN characters, then sends them MSB-first with WriteChar/WriteString
// strobes; first bit one cycle after start, no backpressure once sending (writes refused outside FILL).
module string_tx
    import pov_pkg::*;
#(
    parameter int CHAR_W  = CHAR_W_DEF,
    parameter int STR_LEN = STR_LEN_DEF,
    parameter int GAP     = GAP_DEF
) (
    input  logic        clk_2,
    input  logic        reset,
    string_tx_if.slave  bus
);
    localparam int PW = cnt_w(STR_LEN);
    localparam int BW = cnt_w(CHAR_W);
    localparam int GW = cnt_w(GAP);
    localparam logic [PW-1:0] LAST    = PW'(STR_LEN - 1);
    localparam logic [BW-1:0] BIT_TOP = BW'(CHAR_W - 1);
    localparam logic [GW-1:0] GAP_TOP = GW'(GAP - 1);

    tx_state_t         state;
    logic [CHAR_W-1:0] mem [STR_LEN];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     chr_idx;
    logic [BW-1:0]     bit_idx;
    logic [GW-1:0]     gap_cnt;
    logic              char_ready, busy, done, write_char, write_string;
    logic              start_go, next_chr, tx_bit;
    logic [PW-1:0]     ld_idx;

    assign start_go = (state == ST_ARMED) && bus.start;
    assign next_chr = (state == ST_GAP) && (gap_cnt == '0) && (chr_idx != LAST);
    assign ld_idx   = start_go ? '0 : chr_idx + PW'(1);

    // Buffer is deliberately left out of reset; only FILL may change it.
    always_ff @(posedge clk_2) begin
        if (!reset && state == ST_FILL && bus.char_we)
            mem[wr_ptr] <= bus.char_in;
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            state        <= ST_FILL;
            wr_ptr       <= '0;
            chr_idx      <= '0;
            bit_idx      <= BIT_TOP;
            gap_cnt      <= '0;
            char_ready   <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            write_char   <= 1'b0;
            write_string <= 1'b0;
        end else begin
            done         <= 1'b0;
            write_string <= 1'b0;
            case (state)
                ST_FILL: begin
                    if (bus.char_we) begin
                        if (wr_ptr == LAST) begin
                            state      <= ST_ARMED;
                            wr_ptr     <= '0;
                            char_ready <= 1'b0;
                        end else begin
                            wr_ptr <= wr_ptr + PW'(1);
                        end
                    end
                end
                ST_ARMED: begin
                    if (bus.start) begin
                        state      <= ST_SEND;
                        chr_idx    <= '0;
                        bit_idx    <= BIT_TOP;
                        busy       <= 1'b1;
                        write_char <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (bit_idx == '0) begin
                        state        <= ST_GAP;
                        gap_cnt      <= GAP_TOP;
                        write_char   <= 1'b0;
                        write_string <= 1'b1;
                    end else begin
                        bit_idx <= bit_idx - BW'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end else if (chr_idx == LAST) begin
                        state      <= ST_FILL;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        char_ready <= 1'b1;
                    end else begin
                        state      <= ST_SEND;
                        chr_idx    <= chr_idx + PW'(1);
                        bit_idx    <= BIT_TOP;
                        write_char <= 1'b1;
                    end
                end
                default: state <= ST_FILL;
            endcase
        end
    end

    char_shifter #(.W(CHAR_W)) u_shifter (
        .clk_2 (clk_2),
        .reset (reset),
        .load  (start_go || next_chr),
        .shift (state == ST_SEND),
        .dat   (mem[ld_idx]),
        .msb   (tx_bit)
    );

    assign bus.char_ready  = char_ready;
    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.TxData      = tx_bit;
    assign bus.WriteChar   = write_char;
    assign bus.WriteString = write_string;
endmodule

// File: tb/tb_string_tx.sv
// Directed bench for string_tx: two instances (GAP=1 and GAP=3) share one stimulus stream
// and their serial output is decoded back into characters and framing statistics.
module tb_string_tx;
    import pov_pkg::*;

    logic       clk_2 = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] cin   = '0;
    logic       cwe   = 1'b0;
    logic       start = 1'b0;
    int         checks = 0;
    int         failures = 0;

    always #5 clk_2 = ~clk_2;

    string_tx_if #(.CHAR_W(8)) ia ();
    string_tx_if #(.CHAR_W(8)) ib ();

    assign ia.char_in = cin;
    assign ia.char_we = cwe;
    assign ia.start   = start;
    assign ib.char_in = cin;
    assign ib.char_we = cwe;
    assign ib.start   = start;

    string_tx #(.CHAR_W(8), .STR_LEN(12), .GAP(1)) dut_a (.clk_2(clk_2), .reset(reset), .bus(ia));
    string_tx #(.CHAR_W(8), .STR_LEN(12), .GAP(3)) dut_b (.clk_2(clk_2), .reset(reset), .bus(ib));

    logic [1:0] ready_v, busy_v, done_v, tx_v, wc_v, ws_v;
    assign ready_v = {ib.char_ready, ia.char_ready};
    assign busy_v  = {ib.busy, ia.busy};
    assign done_v  = {ib.done, ia.done};
    assign tx_v    = {ib.TxData, ia.TxData};
    assign wc_v    = {ib.WriteChar, ia.WriteChar};
    assign ws_v    = {ib.WriteString, ia.WriteString};

    logic [7:0] msg1 [12];
    logic [7:0] msg2 [12];
    logic [7:0] rx [2][12];
    int busy_c [2], done_c [2], done_k [2], last_busy [2], nbit [2];
    int bursts [2], ws_c [2], ws_bad [2], tx_bad [2], gap_c [2];
    logic prev_wc [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] msg_chr(input int m, input int i);
        return (m == 1) ? msg1[i] : msg2[i];
    endfunction

    // One write per cycle; entered and left on a falling edge.
    task automatic write_range(input int m, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            cin = msg_chr(m, i);
            cwe = 1'b1;
            @(negedge clk_2);
        end
        cwe = 1'b0;
    endtask

    // Called right after start is raised; sample k is the k-th cycle after the start edge.
    task automatic capture(input int pulse1, input int pulse2);
        for (int d = 0; d < 2; d++) begin
            busy_c[d] = 0; done_c[d] = 0; done_k[d] = 0; last_busy[d] = 0; nbit[d] = 0;
            bursts[d] = 0; ws_c[d] = 0; ws_bad[d] = 0; tx_bad[d] = 0; gap_c[d] = 0;
            prev_wc[d] = 1'b0;
            for (int i = 0; i < 12; i++) rx[d][i] = '0;
        end
        for (int k = 1; k <= 150; k++) begin
            @(negedge clk_2);
            start = (k == pulse1) || (k == pulse2);
            for (int d = 0; d < 2; d++) begin
                if (busy_v[d]) begin
                    busy_c[d]++;
                    last_busy[d] = k;
                    if (!wc_v[d]) gap_c[d]++;
                end
                if (done_v[d]) begin
                    done_c[d]++;
                    done_k[d] = k;
                end
                if (wc_v[d]) begin
                    if (nbit[d] < 96) rx[d][nbit[d] / 8] = {rx[d][nbit[d] / 8][6:0], tx_v[d]};
                    nbit[d]++;
                    if (!prev_wc[d]) bursts[d]++;
                end else if (tx_v[d]) begin
                    tx_bad[d]++;
                end
                if (ws_v[d]) begin
                    ws_c[d]++;
                    if (!prev_wc[d]) ws_bad[d]++;
                end
                prev_wc[d] = wc_v[d];
            end
        end
        start = 1'b0;
    endtask

    task automatic check_tx(input string tag, input int m);
        int len, gap;
        for (int d = 0; d < 2; d++) begin
            gap = (d == 0) ? 1 : 3;
            len = 12 * (8 + gap);
            check($sformatf("%s/d%0d/busy_cycles", tag, d), busy_c[d], len);
            check($sformatf("%s/d%0d/busy_last", tag, d), last_busy[d], len);
            check($sformatf("%s/d%0d/done_count", tag, d), done_c[d], 1);
            check($sformatf("%s/d%0d/done_cycle", tag, d), done_k[d], len + 1);
            check($sformatf("%s/d%0d/char_bits", tag, d), nbit[d], 96);
            check($sformatf("%s/d%0d/wc_bursts", tag, d), bursts[d], 12);
            check($sformatf("%s/d%0d/ws_pulses", tag, d), ws_c[d], 12);
            check($sformatf("%s/d%0d/ws_misplaced", tag, d), ws_bad[d], 0);
            check($sformatf("%s/d%0d/tx_outside_wc", tag, d), tx_bad[d], 0);
            check($sformatf("%s/d%0d/gap_cycles", tag, d), gap_c[d], 12 * gap);
            check($sformatf("%s/d%0d/ready_after", tag, d), ready_v[d], 1);
            for (int i = 0; i < 12; i++)
                check($sformatf("%s/d%0d/char%0d", tag, d, i), rx[d][i], msg_chr(m, i));
        end
    endtask

    initial begin
        string s1, s2;
        int    cnt;
        s1 = "HELLO WORLD!";
        s2 = "POV-DISPLAY7";
        for (int i = 0; i < 12; i++) begin
            msg1[i] = s1[i];
            msg2[i] = s2[i];
        end

        // Reset state
        repeat (3) @(negedge clk_2);
        check("rst/char_ready", ready_v, 2'b11);
        check("rst/busy", busy_v, 2'b00);
        check("rst/done", done_v, 2'b00);
        check("rst/TxData", tx_v, 2'b00);
        check("rst/WriteChar", wc_v, 2'b00);
        check("rst/WriteString", ws_v, 2'b00);
        reset = 1'b0;
        @(negedge clk_2);

        // Fill and send "HELLO WORLD!"; char 0 is 0x48 -> 0,1,0,0,1,0,0,0
        write_range(1, 0, 11);
        check("fill/char_ready_low", ready_v, 2'b00);
        start = 1'b1;
        capture(0, 0);
        check_tx("send1", 1);

        // Partial fill: 11 writes, start must be ignored
        write_range(2, 0, 10);
        check("partial/ready", ready_v, 2'b11);
        start = 1'b1;
        @(negedge clk_2);
        start = 1'b0;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_2);
            if (wc_v != 2'b00 || busy_v != 2'b00) cnt++;
        end
        check("partial/no_tx_cycles", cnt, 0);
        check("partial/ready_held", ready_v, 2'b11);
        write_range(2, 11, 11);
        start = 1'b1;
        capture(0, 0);
        check_tx("partial", 2);

        // Overwrite guard: a 13th write while ARMED must not land
        write_range(1, 0, 11);
        cin = 8'hFF;
        cwe = 1'b1;
        @(negedge clk_2);
        cwe = 1'b0;
        start = 1'b1;
        capture(0, 0);
        check_tx("overwrite", 1);

        // Restart guard: start pulses mid-transmission are ignored
        write_range(2, 0, 11);
        start = 1'b1;
        capture(5, 50);
        check_tx("restart", 2);

        // Reset 40 cycles into a transmission
        write_range(2, 0, 11);
        start = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_2);
            start = 1'b0;
        end
        check("midrst/busy_before", busy_v, 2'b11);
        reset = 1'b1;
        @(negedge clk_2);
        check("midrst/WriteChar", wc_v, 2'b00);
        check("midrst/WriteString", ws_v, 2'b00);
        check("midrst/busy", busy_v, 2'b00);
        check("midrst/char_ready", ready_v, 2'b11);
        reset = 1'b0;
        @(negedge clk_2);
        write_range(1, 0, 11);
        start = 1'b1;
        capture(0, 0);
        check_tx("after_rst", 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
